// File: rtl/aes128_pkg.sv
// Shared definitions for the AES-128 word-serial front end: loader state
// encoding and the word geometry of the 128-bit core buses.
package aes128_pkg;

  localparam int AES_WORDS  = 4;
  localparam int AES_WORD_W = 32;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/aes128_word_serializer.sv
// Captures the four ciphertext words on a strobe and streams them out
// word 0 first over a valid/ready handshake; done pulses on the final handshake.
module aes128_word_serializer
  import aes128_pkg::*;
#(
  parameter int WORD_W = AES_WORD_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              capture,
  input  logic [AES_WORDS-1:0][WORD_W-1:0]  words,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [WORD_W-1:0]                 out_data,
  output logic                              out_last,
  output logic                              done
);

  localparam logic [1:0] LAST_IDX = 2'(AES_WORDS - 1);

  logic [AES_WORDS-1:0][WORD_W-1:0] buffer_reg;
  logic [1:0]                       out_cnt_reg;
  logic                             valid_reg;
  logic                             handshake;

  assign handshake = valid_reg && out_ready;

  // Snapshot the core's ciphertext when the loader says the latency has elapsed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer_reg <= '0;
    end else if (capture) begin
      buffer_reg <= words;
    end
  end

  // Walk the word index on each handshake and drop valid after the last word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt_reg <= 2'd0;
      valid_reg   <= 1'b0;
    end else if (capture) begin
      out_cnt_reg <= 2'd0;
      valid_reg   <= 1'b1;
    end else if (handshake) begin
      out_cnt_reg <= out_cnt_reg + 2'd1;
      if (out_cnt_reg == LAST_IDX) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = buffer_reg[out_cnt_reg];
  assign out_last  = valid_reg && (out_cnt_reg == LAST_IDX);
  assign done      = handshake && (out_cnt_reg == LAST_IDX);

endmodule

// File: rtl/aes128_stream_loader.sv
// Word-serial front end for aes128_top: assembles key and plaintext from a
// 32-bit stream, waits a fixed core latency, then streams the ciphertext back.
module aes128_stream_loader
  import aes128_pkg::*;
#(
  parameter int LATENCY = 11,
  parameter int WORD_W  = AES_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_is_key,
  output logic [WORD_W-1:0] key_0,
  output logic [WORD_W-1:0] key_1,
  output logic [WORD_W-1:0] key_2,
  output logic [WORD_W-1:0] key_3,
  output logic [WORD_W-1:0] plain_text_0,
  output logic [WORD_W-1:0] plain_text_1,
  output logic [WORD_W-1:0] plain_text_2,
  output logic [WORD_W-1:0] plain_text_3,
  input  logic [WORD_W-1:0] cipher_text_0,
  input  logic [WORD_W-1:0] cipher_text_1,
  input  logic [WORD_W-1:0] cipher_text_2,
  input  logic [WORD_W-1:0] cipher_text_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              key_loaded,
  output logic              err
);

  // Wide enough to hold LATENCY-1; a single bit when LATENCY is 1
  localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [1:0] LAST_IDX = 2'(AES_WORDS - 1);

  state_t                           state_reg;
  state_t                           state_next;
  logic [1:0]                       key_cnt_reg;
  logic [1:0]                       pt_cnt_reg;
  logic                             key_loaded_reg;
  logic                             err_reg;
  logic [WAIT_W-1:0]                wait_cnt_reg;
  logic [AES_WORDS-1:0][WORD_W-1:0] key_reg;
  logic [AES_WORDS-1:0][WORD_W-1:0] pt_reg;
  logic [AES_WORDS-1:0][WORD_W-1:0] cipher_words;
  logic [AES_WORDS-1:0]             key_we;
  logic [AES_WORDS-1:0]             pt_we;

  logic in_accept;
  logic key_accept;
  logic pt_store;
  logic pt_drop;
  logic block_full;
  logic capture;
  logic ser_done;

  assign in_accept  = in_valid && in_ready;
  assign key_accept = in_accept && in_is_key;
  assign pt_store   = in_accept && !in_is_key && key_loaded_reg;
  assign pt_drop    = in_accept && !in_is_key && !key_loaded_reg;
  assign block_full = pt_store && (pt_cnt_reg == LAST_IDX);

  // One write enable per word slot, selected by the running word counters
  generate
    for (genvar gi = 0; gi < AES_WORDS; gi++) begin : g_word_we
      assign key_we[gi] = key_accept && (key_cnt_reg == 2'(gi));
      assign pt_we[gi]  = pt_store   && (pt_cnt_reg  == 2'(gi));
    end
  endgenerate

  // Key and plaintext word registers that drive the core's 128-bit buses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_reg <= '0;
      pt_reg  <= '0;
    end else begin
      for (int i = 0; i < AES_WORDS; i++) begin
        if (key_we[i]) key_reg[i] <= in_data;
        if (pt_we[i])  pt_reg[i]  <= in_data;
      end
    end
  end

  // Word counters, key status, drop pulse and core latency countdown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_cnt_reg    <= 2'd0;
      pt_cnt_reg     <= 2'd0;
      key_loaded_reg <= 1'b0;
      err_reg        <= 1'b0;
      wait_cnt_reg   <= '0;
    end else begin
      err_reg <= pt_drop;
      if (key_accept) begin
        key_cnt_reg <= key_cnt_reg + 2'd1;
        // A fresh key invalidates the old one and any half-built plaintext
        if (key_cnt_reg == 2'd0) begin
          key_loaded_reg <= 1'b0;
          pt_cnt_reg     <= 2'd0;
        end
        if (key_cnt_reg == LAST_IDX) begin
          key_loaded_reg <= 1'b1;
        end
      end
      if (pt_store) begin
        pt_cnt_reg <= pt_cnt_reg + 2'd1;
      end
      if (block_full) begin
        wait_cnt_reg <= WAIT_W'(LATENCY - 1);
      end else if (state_reg == S_WAIT && wait_cnt_reg != '0) begin
        wait_cnt_reg <= wait_cnt_reg - WAIT_W'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: load words, wait out the core latency, drain the result
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_LOAD:  if (block_full)          state_next = S_WAIT;
      S_WAIT:  if (wait_cnt_reg == '0)  state_next = S_OUT;
      S_OUT:   if (ser_done)            state_next = S_LOAD;
      default:                          state_next = S_LOAD;
    endcase
  end

  // FSM outputs; ready is held low while reset is asserted
  always_comb begin
    in_ready = 1'b0;
    capture  = 1'b0;
    case (state_reg)
      S_LOAD:  in_ready = reset;
      S_WAIT:  capture  = (wait_cnt_reg == '0);
      default: ;
    endcase
  end

  assign cipher_words = {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0};

  aes128_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .words     (cipher_words),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (ser_done)
  );

  assign key_0        = key_reg[0];
  assign key_1        = key_reg[1];
  assign key_2        = key_reg[2];
  assign key_3        = key_reg[3];
  assign plain_text_0 = pt_reg[0];
  assign plain_text_1 = pt_reg[1];
  assign plain_text_2 = pt_reg[2];
  assign plain_text_3 = pt_reg[3];
  assign key_loaded   = key_loaded_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_aes128_stream_loader.sv
// Self-checking bench for aes128_stream_loader with an XOR stub core.
module tb_aes128_stream_loader;

  localparam int LATENCY = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_is_key;
  logic [31:0] in_data;
  logic [31:0] key_0, key_1, key_2, key_3;
  logic [31:0] plain_text_0, plain_text_1, plain_text_2, plain_text_3;
  logic [31:0] cipher_text_0, cipher_text_1, cipher_text_2, cipher_text_3;
  logic        out_valid, out_ready, out_last, key_loaded, err;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  // Stub core: ciphertext is plaintext XOR key, combinational
  assign cipher_text_0 = plain_text_0 ^ key_0;
  assign cipher_text_1 = plain_text_1 ^ key_1;
  assign cipher_text_2 = plain_text_2 ^ key_2;
  assign cipher_text_3 = plain_text_3 ^ key_3;

  aes128_stream_loader #(.LATENCY(LATENCY), .WORD_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_is_key(in_is_key),
    .key_0(key_0), .key_1(key_1), .key_2(key_2), .key_3(key_3),
    .plain_text_0(plain_text_0), .plain_text_1(plain_text_1),
    .plain_text_2(plain_text_2), .plain_text_3(plain_text_3),
    .cipher_text_0(cipher_text_0), .cipher_text_1(cipher_text_1),
    .cipher_text_2(cipher_text_2), .cipher_text_3(cipher_text_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .key_loaded(key_loaded), .err(err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- reference model (word-group level) ----------------
  logic [31:0] key_part_q[$];
  logic [31:0] pt_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] cur_key [4];
  logic        m_key_valid;
  logic [31:0] got [4];

  task automatic model_reset();
    key_part_q.delete();
    pt_q.delete();
    exp_q.delete();
    m_key_valid = 1'b0;
    for (int i = 0; i < 4; i++) cur_key[i] = 32'h0;
  endtask

  task automatic model_word(input logic is_key, input logic [31:0] d,
                            output logic dropped, output logic done);
    dropped = 1'b0;
    done    = 1'b0;
    if (is_key) begin
      if (key_part_q.size() == 0) begin
        m_key_valid = 1'b0;
        pt_q.delete();
      end
      key_part_q.push_back(d);
      if (key_part_q.size() == 4) begin
        for (int i = 0; i < 4; i++) cur_key[i] = key_part_q[i];
        key_part_q.delete();
        m_key_valid = 1'b1;
      end
    end else if (!m_key_valid) begin
      dropped = 1'b1;
    end else begin
      pt_q.push_back(d);
      if (pt_q.size() == 4) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(pt_q[i] ^ cur_key[i]);
        pt_q.delete();
        done = 1'b1;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input logic is_key, input logic [31:0] d);
    int t = 0;
    in_is_key = is_key;
    in_data   = d;
    in_valid  = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) fail_timeout("in_ready wait");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_word(input logic is_key, input logic [31:0] d, output logic done);
    logic dropped;
    model_word(is_key, d, dropped, done);
    send_word(is_key, d);
    check_bit("err after word", err, dropped);
    check_bit("key_loaded after word", key_loaded, m_key_valid);
  endtask

  // Counts edges from the 4th plaintext accept to the first visible out_valid
  task automatic wait_first_out();
    int n = 0;
    while (!out_valid && n < LATENCY + 20) begin
      if (n == 1) check_bit("in_ready during wait", in_ready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) fail_timeout("first out_valid");
    else check_word("first out_valid cycle", 32'(n + 1), 32'(LATENCY + 1));
  endtask

  task automatic recv_words(input int n, input bit rand_ready);
    logic [31:0] exp;
    for (int k = 0; k < n; k++) begin
      int  t     = 0;
      bit  found = 0;
      while (t < 200) begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (k == 0 && t == 0) check_bit("in_ready during out", in_ready, 1'b0);
        if (out_valid && out_ready) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
          check_word("out_data", out_data, exp);
          check_bit("out_last", out_last, 1'(k == n - 1));
          got[k] = out_data;
          @(posedge clk); #1;
          found = 1;
          break;
        end
        @(posedge clk); #1;
        t++;
      end
      if (!found) fail_timeout("out word handshake");
    end
    out_ready = 1'b0;
    check_bit("out_valid after last", out_valid, 1'b0);
    check_bit("in_ready after last", in_ready, 1'b1);
  endtask

  // ---------------- basic-block vector table ----------------
  typedef struct packed {
    logic        is_key;
    logic [31:0] data;
    logic        exp_loaded;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] exp_out [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        done;
    logic        dropped;
    int          seen;
    logic [31:0] pw [4];

    vecs[0] = '{1'b1, 32'h04030201, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h08070605, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h0C0B0A09, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h100F0E0D, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h6F6E6F43, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h6F4E2072, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h206E616C, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h54494D47, 1'b1, 1'b0};
    exp_out[0] = 32'h6B6D6D42;
    exp_out[1] = 32'h67492677;
    exp_out[2] = 32'h2C656B65;
    exp_out[3] = 32'h4446434A;

    reset = 1'b0; in_valid = 1'b0; in_is_key = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset in_ready", in_ready, 1'b0);
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset out_last", out_last, 1'b0);
    check_bit("reset key_loaded", key_loaded, 1'b0);
    check_bit("reset err", err, 1'b0);
    check_word("reset key_0", key_0, 32'h0);
    check_word("reset plain_text_3", plain_text_3, 32'h0);
    check_word("reset out_data", out_data, 32'h0);
    reset = 1'b1;
    #1;
    check_bit("in_ready after release", in_ready, 1'b1);

    // Plaintext before any key: every word dropped with an err pulse
    for (int i = 0; i < 4; i++) do_word(1'b0, $urandom, done);
    @(posedge clk); #1;
    check_bit("err single pulse", err, 1'b0);
    seen = 0;
    repeat (LATENCY + 4) begin
      if (out_valid || !in_ready) seen++;
      @(posedge clk); #1;
    end
    check_word("no block from dropped pt", 32'(seen), 32'h0);

    // Basic block from the vector table
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      model_word(vecs[i].is_key, vecs[i].data, dropped, done);
      send_word(vecs[i].is_key, vecs[i].data);
      check_bit("table key_loaded", key_loaded, vecs[i].exp_loaded);
      check_bit("table err", err, vecs[i].exp_err);
    end
    wait_first_out();
    recv_words(4, 1'b0);
    for (int k = 0; k < 4; k++) check_word("basic cipher word", got[k], exp_out[k]);

    // Backpressure on the same key and plaintext; key reused without reload
    for (int i = 4; i < 8; i++) do_word(1'b0, vecs[i].data, done);
    wait_first_out();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_is_key = 1'b1; in_data = 32'hDEADBEEF;
    repeat (10) begin
      check_word("bp hold data", out_data, 32'h6B6D6D42);
      check_bit("bp in_ready", in_ready, 1'b0);
      check_bit("bp out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_word("in_valid ignored when not ready", key_0, 32'h04030201);
    recv_words(4, 1'b0);

    // Key reload mid-plaintext: partial group discarded, zero key passes data through
    for (int i = 0; i < 2; i++) do_word(1'b0, $urandom, done);
    for (int i = 0; i < 4; i++) do_word(1'b1, 32'h0, done);
    for (int i = 0; i < 4; i++) begin
      pw[i] = $urandom;
      do_word(1'b0, pw[i], done);
    end
    wait_first_out();
    recv_words(4, 1'b0);
    for (int k = 0; k < 4; k++) check_word("reload passthrough", got[k], pw[k]);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) begin
        do_word(1'b1, $urandom, done);
      end else if (r == 1) begin
        for (int j = 0; j < 4; j++) do_word(1'b1, $urandom, done);
      end else begin
        do_word(1'b0, $urandom, done);
        if (done) begin
          wait_first_out();
          recv_words(4, 1'b1);
        end
      end
    end

    // Reset in the middle of the latency wait
    while (key_part_q.size() != 0) do_word(1'b1, $urandom, done);
    for (int i = 0; i < 4; i++) do_word(1'b1, $urandom, done);
    for (int i = 0; i < 4; i++) do_word(1'b0, $urandom, done);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_bit("midreset in_ready", in_ready, 1'b0);
    check_bit("midreset out_valid", out_valid, 1'b0);
    check_bit("midreset key_loaded", key_loaded, 1'b0);
    check_word("midreset key_2", key_2, 32'h0);
    check_word("midreset plain_text_1", plain_text_1, 32'h0);
    check_word("midreset out_data", out_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_bit("post reset in_ready", in_ready, 1'b1);
    check_bit("post reset key_loaded", key_loaded, 1'b0);
    seen = 0;
    repeat (LATENCY + 5) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check_word("no output after reset", 32'(seen), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
